// File: rtl/msx_slot_mapper.sv
// MSX slot mapper: primary/secondary slot registers, page decode and a memory-access handshake.
// Optional WAIT-state abort counter is enabled by defining MSX_SLOT_MAPPER_TIMEOUT_EN.
module msx_slot_mapper #(
    parameter logic [3:0]  EXP_MASK = 4'b1000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic        cpu_mreq,
    input  logic        cpu_iorq,
    output logic        cpu_wait,
    output logic [1:0]  sel_slot,
    output logic [1:0]  sel_subslot,
    output logic [1:0]  sel_page,
    output logic        mem_req,
    output logic        mem_we,
    input  logic        mem_ready,
    input  logic [7:0]  mem_dout
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
        $error("TIMEOUT must be in 1..255");
    end

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_t;

    state_t     state_q, state_d;
    logic [7:0] psl_q;
    logic [7:0] ssl_q [4];
    logic [7:0] data_q, data_d;
    logic       we_q;
    logic [1:0] slot_q, sub_q, page_q;

    logic       psl_hit, ssl_hit, start;
    logic [1:0] dec_page, dec_slot, dec_sub;

`ifdef MSX_SLOT_MAPPER_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);
    logic [7:0] cnt_q, cnt_d;
`endif

    // The SSL register is addressed through whichever slot is mapped into page 3.
    always_comb begin
        psl_hit  = cpu_iorq && (cpu_addr[7:0] == 8'hA8);
        ssl_hit  = cpu_mreq && (cpu_addr == 16'hFFFF) && EXP_MASK[psl_q[7:6]];
        start    = cpu_mreq && (cpu_rd || cpu_wr) && !ssl_hit;
        dec_page = cpu_addr[15:14];
        dec_slot = psl_q[{dec_page, 1'b0} +: 2];
        dec_sub  = EXP_MASK[dec_slot] ? ssl_q[dec_slot][{dec_page, 1'b0} +: 2] : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            psl_q   <= 8'h00;
            for (int i = 0; i < 4; i++) begin
                ssl_q[i] <= 8'h00;
            end
            data_q  <= 8'hFF;
            we_q    <= 1'b0;
            slot_q  <= 2'b00;
            sub_q   <= 2'b00;
            page_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            if (psl_hit && cpu_wr) begin
                psl_q <= cpu_dout;
            end
            if (ssl_hit && cpu_wr) begin
                ssl_q[psl_q[7:6]] <= cpu_dout;
            end
            if (state_q == StIdle && start) begin
                we_q   <= cpu_wr;
                slot_q <= dec_slot;
                sub_q  <= dec_sub;
                page_q <= dec_page;
            end
        end
    end

`ifdef MSX_SLOT_MAPPER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        cpu_wait = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
`ifdef MSX_SLOT_MAPPER_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    cpu_wait = 1'b1;
                    data_d   = 8'hFF;
                    state_d  = StReq;
                end
            end
            StReq: begin
                cpu_wait = 1'b1;
                mem_req  = 1'b1;
                mem_we   = we_q;
                state_d  = StWait;
`ifdef MSX_SLOT_MAPPER_TIMEOUT_EN
                cnt_d    = 8'd0;
`endif
            end
            StWait: begin
                cpu_wait = 1'b1;
                if (mem_ready) begin
                    if (!we_q) begin
                        data_d = mem_dout;
                    end
                    state_d = StDone;
                end
`ifdef MSX_SLOT_MAPPER_TIMEOUT_EN
                else if (cnt_q == TimeoutLast) begin
                    data_d  = 8'hFF;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            StDone: begin
                if (!cpu_mreq) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Decode is live in IDLE and frozen for the whole in-flight access.
    always_comb begin
        if (state_q == StIdle) begin
            sel_slot    = dec_slot;
            sel_subslot = dec_sub;
            sel_page    = dec_page;
        end else begin
            sel_slot    = slot_q;
            sel_subslot = sub_q;
            sel_page    = page_q;
        end
    end

    always_comb begin
        cpu_din = 8'hFF;
        if (cpu_rd) begin
            if (psl_hit) begin
                cpu_din = psl_q;
            end else if (ssl_hit) begin
                cpu_din = ~ssl_q[psl_q[7:6]];
            end else if (state_q == StDone) begin
                cpu_din = data_q;
            end
        end
    end

endmodule
